// File: rtl/goblin_ctrl.sv
// Goblin movement controller: paces moves by a tick divider, steers toward the
// Digger over passable tunnel tiles and latches a sticky catch.
module goblin_ctrl #(
    parameter int MOVE_DIV = 4,
    parameter int START_X  = 0,
    parameter int START_Y  = 14
) (
    input  logic       Clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] Digx,
    input  logic [3:0] Digy,
    input  logic [2:0] up,
    input  logic [2:0] down,
    input  logic [2:0] left,
    input  logic [2:0] right,
    output logic [3:0] Gobx,
    output logic [3:0] Goby,
    output logic [1:0] dir,
    output logic       moving,
    output logic       caught
);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_DECIDE = 2'd1,
        S_MOVE   = 2'd2,
        S_CAUGHT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        D_UP    = 2'd0,
        D_DOWN  = 2'd1,
        D_LEFT  = 2'd2,
        D_RIGHT = 2'd3
    } dir_e;

    localparam logic [3:0] CNT_MAX = 4'(MOVE_DIV - 1);
    localparam logic [3:0] ROW_MAX = 4'd9;
    localparam logic [3:0] COL_MAX = 4'd14;
    localparam logic [2:0] TUNNEL  = 3'd0;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] gobx_q, gobx_d;
    logic [3:0] goby_q, goby_d;
    dir_e       dir_q, dir_d;
    dir_e       nxt_q, nxt_d;
    logic       last_valid_q, last_valid_d;
    logic       moving_q, moving_d;

    logic [4:0] dx, dy, adx, ady;
    logic       vert_primary;
    logic [3:0] open_dir;
    logic [3:0] rank [4];
    logic [3:0] best;
    logic       found;
    dir_e       sel;

    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q      <= S_WAIT;
            cnt_q        <= '0;
            gobx_q       <= 4'(START_X);
            goby_q       <= 4'(START_Y);
            dir_q        <= D_UP;
            nxt_q        <= D_UP;
            last_valid_q <= 1'b0;
            moving_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gobx_q       <= gobx_d;
            goby_q       <= goby_d;
            dir_q        <= dir_d;
            nxt_q        <= nxt_d;
            last_valid_q <= last_valid_d;
            moving_q     <= moving_d;
        end
    end

    // Candidate list expressed as a rank per direction (toward dirs 0/1, fixed
    // order 2..5, demoted reverse 8); the lowest-ranked open direction wins.
    always_comb begin
        dx = {1'b0, Digx} - {1'b0, gobx_q};
        dy = {1'b0, Digy} - {1'b0, goby_q};
        adx = dx[4] ? (5'd0 - dx) : dx;
        ady = dy[4] ? (5'd0 - dy) : dy;
        vert_primary = (adx >= ady);

        open_dir[D_UP]    = (up    == TUNNEL) && (gobx_q != 4'd0);
        open_dir[D_DOWN]  = (down  == TUNNEL) && (gobx_q <  ROW_MAX);
        open_dir[D_LEFT]  = (left  == TUNNEL) && (goby_q != 4'd0);
        open_dir[D_RIGHT] = (right == TUNNEL) && (goby_q <  COL_MAX);

        rank[D_UP]    = 4'd2;
        rank[D_LEFT]  = 4'd3;
        rank[D_DOWN]  = 4'd4;
        rank[D_RIGHT] = 4'd5;
        if (dx != 5'd0) begin
            rank[dx[4] ? D_UP : D_DOWN] = vert_primary ? 4'd0 : 4'd1;
        end
        if (dy != 5'd0) begin
            rank[dy[4] ? D_LEFT : D_RIGHT] = vert_primary ? 4'd1 : 4'd0;
        end
        if (last_valid_q) begin
            rank[dir_q ^ 2'b01] = 4'd8;
        end

        found = 1'b0;
        best  = 4'hF;
        sel   = D_UP;
        for (int unsigned i = 0; i < 4; i++) begin
            if (open_dir[i[1:0]] && (rank[i[1:0]] < best)) begin
                best  = rank[i[1:0]];
                sel   = dir_e'(i[1:0]);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gobx_d       = gobx_q;
        goby_d       = goby_q;
        dir_d        = dir_q;
        nxt_d        = nxt_q;
        last_valid_d = last_valid_q;
        moving_d     = 1'b0;

        case (state_q)
            S_WAIT: begin
                if ((gobx_q == Digx) && (goby_q == Digy)) begin
                    state_d = S_CAUGHT;
                end else if (tick) begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d   = '0;
                        state_d = S_DECIDE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_DECIDE: begin
                if (found) begin
                    nxt_d   = sel;
                    state_d = S_MOVE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_MOVE: begin
                case (nxt_q)
                    D_UP:    gobx_d = gobx_q - 4'd1;
                    D_DOWN:  gobx_d = gobx_q + 4'd1;
                    D_LEFT:  goby_d = goby_q - 4'd1;
                    D_RIGHT: goby_d = goby_q + 4'd1;
                    default: gobx_d = gobx_q;
                endcase
                dir_d        = nxt_q;
                last_valid_d = 1'b1;
                moving_d     = 1'b1;
                state_d      = S_WAIT;
            end
            S_CAUGHT: begin
                state_d = S_CAUGHT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        Gobx   = gobx_q;
        Goby   = goby_q;
        dir    = dir_q;
        moving = moving_q;
        caught = (state_q == S_CAUGHT);
    end

endmodule

// File: tb/tb_goblin_ctrl.sv
// Bench for goblin_ctrl: directed steps on a MOVE_DIV=1 instance, then divider
// and randomized map runs on a MOVE_DIV=4 instance against a reference model.
module tb_goblin_ctrl;

    localparam int DIV4 = 4;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int ntests = 0;
    int nfail  = 0;

    logic       rst1, tick1;
    logic [3:0] digx1, digy1;
    logic [2:0] up1, dn1, lf1, rt1;
    logic [3:0] gx1, gy1;
    logic [1:0] dir1;
    logic       mov1, cau1;

    logic       rst4, tick4;
    logic [3:0] digx4, digy4;
    logic [2:0] up4, dn4, lf4, rt4;
    logic [3:0] gx4, gy4;
    logic [1:0] dir4;
    logic       mov4, cau4;

    goblin_ctrl #(.MOVE_DIV(1), .START_X(0), .START_Y(14)) dut1 (
        .Clk(Clk), .rst(rst1), .tick(tick1), .Digx(digx1), .Digy(digy1),
        .up(up1), .down(dn1), .left(lf1), .right(rt1),
        .Gobx(gx1), .Goby(gy1), .dir(dir1), .moving(mov1), .caught(cau1)
    );

    goblin_ctrl #(.MOVE_DIV(DIV4), .START_X(0), .START_Y(14)) dut4 (
        .Clk(Clk), .rst(rst4), .tick(tick4), .Digx(digx4), .Digy(digy4),
        .up(up4), .down(dn4), .left(lf4), .right(rt4),
        .Gobx(gx4), .Goby(gy4), .dir(dir4), .moving(mov4), .caught(cau4)
    );

    logic [2:0] tmap [10][15];

    // reference model state for dut4
    int mgx, mgy, mdir, mlv, mcnt, mcau, mfl, mnxt, mmov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] tile(input int r, input int c);
        if (r < 0 || r > 9 || c < 0 || c > 14) return 3'd7;
        return tmap[r][c];
    endfunction

    function automatic int rev(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 3 : 2;
    endfunction

    function automatic bit passable(input int d);
        int nr, nc;
        nr = mgx + ((d == 1) ? 1 : 0) - ((d == 0) ? 1 : 0);
        nc = mgy + ((d == 3) ? 1 : 0) - ((d == 2) ? 1 : 0);
        return tile(nr, nc) == 3'd0;
    endfunction

    function automatic int choose();
        int q[$];
        int order[4] = '{0, 2, 1, 3};
        int dx, dy, v, h, adx, ady, rv;
        dx  = int'(digx4) - mgx;
        dy  = int'(digy4) - mgy;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        v = (dx < 0) ? 0 : (dx > 0) ? 1 : -1;
        h = (dy < 0) ? 2 : (dy > 0) ? 3 : -1;
        if (adx >= ady) begin
            if (v >= 0) q.push_back(v);
            if (h >= 0) q.push_back(h);
        end else begin
            if (h >= 0) q.push_back(h);
            if (v >= 0) q.push_back(v);
        end
        for (int i = 0; i < 4; i++) begin
            bit seen = 1'b0;
            foreach (q[j]) if (q[j] == order[i]) seen = 1'b1;
            if (!seen) q.push_back(order[i]);
        end
        if (mlv != 0) begin
            rv = rev(mdir);
            for (int j = 0; j < q.size(); j++) begin
                if (q[j] == rv) begin
                    q.delete(j);
                    break;
                end
            end
            q.push_back(rv);
        end
        for (int j = 0; j < q.size(); j++) if (passable(q[j])) return q[j];
        return -1;
    endfunction

    task automatic m_reset();
        mgx = 0; mgy = 14; mdir = 0; mlv = 0; mcnt = 0; mcau = 0; mfl = 0; mnxt = 0; mmov = 0;
    endtask

    // advances the model by one clock edge using the inputs present before it
    task automatic m_step(input bit t, input bit r);
        mmov = 0;
        if (r) m_reset();
        else if (mcau != 0) begin end
        else if (mfl == 2) begin
            mnxt = choose();
            mfl  = (mnxt < 0) ? 0 : 1;
        end else if (mfl == 1) begin
            if (mnxt == 0) mgx--;
            if (mnxt == 1) mgx++;
            if (mnxt == 2) mgy--;
            if (mnxt == 3) mgy++;
            mdir = mnxt; mlv = 1; mmov = 1; mfl = 0;
        end else if (mgx == int'(digx4) && mgy == int'(digy4)) mcau = 1;
        else if (t) begin
            mcnt++;
            if (mcnt == DIV4) begin
                mcnt = 0;
                mfl  = 2;
            end
        end
    endtask

    task automatic drive_nb4();
        up4 = tile(int'(gx4) - 1, int'(gy4));
        dn4 = tile(int'(gx4) + 1, int'(gy4));
        lf4 = tile(int'(gx4), int'(gy4) - 1);
        rt4 = tile(int'(gx4), int'(gy4) + 1);
    endtask

    task automatic cyc1();
        @(posedge Clk);
        #1;
    endtask

    task automatic cyc4(input bit t, input bit r);
        tick4 = t;
        rst4  = r;
        m_step(t, r);
        @(posedge Clk);
        #1;
        tick4 = 1'b0;
        rst4  = 1'b0;
        drive_nb4();
        chk("m_gobx", gx4, mgx);
        chk("m_goby", gy4, mgy);
        chk("m_dir", dir4, mdir);
        chk("m_moving", mov4, mmov);
        chk("m_caught", cau4, mcau);
    endtask

    initial begin
        int movcnt, nt, first;
        rst4 = 1'b1; tick4 = 1'b0; digx4 = 4'd9; digy4 = 4'd0;
        up4 = 3'd7; dn4 = 3'd7; lf4 = 3'd7; rt4 = 3'd7;
        for (int r = 0; r < 10; r++) for (int c = 0; c < 15; c++) tmap[r][c] = 3'd0;

        // ---- MOVE_DIV=1 directed steps ----
        rst1 = 1'b1; tick1 = 1'b0; digx1 = 4'd5; digy1 = 4'd5;
        up1 = 3'd7; dn1 = 3'd3; lf1 = 3'd0; rt1 = 3'd7;
        cyc1();
        rst1 = 1'b0;
        chk("rst_gobx", gx1, 0);
        chk("rst_goby", gy1, 14);
        chk("rst_dir", dir1, 0);
        chk("rst_moving", mov1, 0);
        chk("rst_caught", cau1, 0);

        tick1 = 1'b1; cyc1(); tick1 = 1'b0;
        chk("lat_n0_goby", gy1, 14);
        cyc1();
        chk("lat_n1_goby", gy1, 14);
        chk("lat_n1_moving", mov1, 0);
        cyc1();
        chk("first_goby", gy1, 13);
        chk("first_gobx", gx1, 0);
        chk("first_dir", dir1, 2);
        chk("first_moving", mov1, 1);
        cyc1();
        chk("first_moving_pulse", mov1, 0);

        up1 = 3'd3; dn1 = 3'd3; lf1 = 3'd3; rt1 = 3'd3;
        movcnt = 0;
        tick1 = 1'b1;
        repeat (10) begin cyc1(); if (mov1) movcnt++; end
        tick1 = 1'b0;
        repeat (3) begin cyc1(); if (mov1) movcnt++; end
        chk("blocked_moves", movcnt, 0);
        chk("blocked_gobx", gx1, 0);
        chk("blocked_goby", gy1, 13);
        chk("blocked_caught", cau1, 0);

        digx1 = 4'd0; digy1 = 4'd14;
        up1 = 3'd7; dn1 = 3'd0; lf1 = 3'd3; rt1 = 3'd0;
        tick1 = 1'b1; cyc1(); tick1 = 1'b0; cyc1(); cyc1();
        chk("demote_dir", dir1, 1);
        chk("demote_gobx", gx1, 1);
        chk("demote_goby", gy1, 13);
        dn1 = 3'd3;
        tick1 = 1'b1; cyc1(); tick1 = 1'b0; cyc1(); cyc1();
        chk("demote2_dir", dir1, 3);
        chk("demote2_goby", gy1, 14);

        digx1 = 4'd1; digy1 = 4'd14;
        cyc1();
        chk("catch_now", cau1, 1);
        up1 = 3'd0; dn1 = 3'd0; lf1 = 3'd0; rt1 = 3'd0;
        movcnt = 0;
        tick1 = 1'b1;
        repeat (20) begin cyc1(); if (mov1) movcnt++; end
        tick1 = 1'b0;
        chk("caught_moves", movcnt, 0);
        chk("caught_gobx", gx1, 1);
        chk("caught_goby", gy1, 14);
        chk("caught_sticky", cau1, 1);
        rst1 = 1'b1; cyc1(); rst1 = 1'b0;
        chk("catch_rst_caught", cau1, 0);
        chk("catch_rst_gobx", gx1, 0);
        chk("catch_rst_goby", gy1, 14);

        digx1 = 4'd0; digy1 = 4'd13;
        up1 = 3'd7; dn1 = 3'd7; lf1 = 3'd0; rt1 = 3'd7;
        tick1 = 1'b1; cyc1(); tick1 = 1'b0; cyc1(); cyc1();
        chk("land_goby", gy1, 13);
        chk("land_caught_early", cau1, 0);
        cyc1();
        chk("land_caught", cau1, 1);
        chk("land_goby_hold", gy1, 13);
        rst1 = 1'b1; cyc1(); rst1 = 1'b0;

        digx1 = 4'd9; digy1 = 4'd0;
        tick1 = 1'b1; cyc1(); tick1 = 1'b0; cyc1();
        rst1 = 1'b1; cyc1(); rst1 = 1'b0;
        chk("rst_in_move_goby", gy1, 14);
        chk("rst_in_move_moving", mov1, 0);

        digx1 = 4'd10; digy1 = 4'd14;
        up1 = 3'd7; dn1 = 3'd0; lf1 = 3'd7; rt1 = 3'd7;
        for (int k = 1; k <= 9; k++) begin
            tick1 = 1'b1; cyc1(); tick1 = 1'b0; cyc1(); cyc1();
            chk("path_gobx", gx1, k);
            cyc1();
        end
        lf1 = 3'd0;
        tick1 = 1'b1; cyc1(); tick1 = 1'b0; cyc1(); cyc1();
        chk("clamp_gobx", gx1, 9);
        chk("clamp_goby", gy1, 13);
        chk("clamp_dir", dir1, 2);
        lf1 = 3'd7;
        movcnt = 0;
        tick1 = 1'b1; cyc1(); tick1 = 1'b0;
        repeat (3) begin cyc1(); if (mov1) movcnt++; end
        chk("clamp_only_down_moves", movcnt, 0);
        chk("clamp_only_down_gobx", gx1, 9);

        // ---- MOVE_DIV=4 divider on an open map ----
        cyc4(1'b0, 1'b1);
        movcnt = 0;
        for (int c = 0; c < 120; c++) begin
            cyc4((c % 3) == 0, 1'b0);
            if (mov4) movcnt++;
        end
        chk("div_moves_120", movcnt, 10);
        cyc4(1'b1, 1'b0); cyc4(1'b0, 1'b0); cyc4(1'b0, 1'b0);
        cyc4(1'b1, 1'b0); cyc4(1'b0, 1'b0); cyc4(1'b0, 1'b0);
        cyc4(1'b1, 1'b1);
        nt = 0; first = -1;
        for (int c = 0; c < 30; c++) begin
            bit t;
            t = ((c % 3) == 0);
            if (t) nt++;
            cyc4(t, 1'b0);
            if (mov4 && first < 0) first = nt;
        end
        chk("div_ticks_after_rst", first, 4);

        // ---- randomized maps, Digger positions and tick patterns ----
        for (int ep = 0; ep < 6; ep++) begin
            for (int r = 0; r < 10; r++)
                for (int c = 0; c < 15; c++)
                    tmap[r][c] = ($urandom_range(0, 99) < 65) ? 3'd0 : 3'($urandom_range(3, 5));
            digx4 = 4'($urandom_range(0, 9));
            digy4 = 4'($urandom_range(0, 14));
            drive_nb4();
            cyc4(1'b0, 1'b1);
            for (int c = 0; c < 300; c++) begin
                if (mfl == 0 && $urandom_range(0, 39) == 0) begin
                    digx4 = 4'($urandom_range(0, 9));
                    digy4 = 4'($urandom_range(0, 14));
                end
                cyc4(1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
